pixel_scanner: RTL and testbench



---
 rtl/pixel_scanner_pkg.sv | 20 ++
 rtl/pixel_scanner_if.sv | 25 ++
 rtl/stall_delay_line.sv | 27 ++
 rtl/pixel_scanner.sv | 138 +++++++++++++
 tb/tb_pixel_scanner.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_scanner_pkg.sv
// Shared types and defaults for the pixel scanner and its downstream users.
// Provides the coordinate type and the sideband tag carried alongside each ray.
package pixel_scanner_pkg;

    localparam int H_RES_DEFAULT   = 800;
    localparam int V_RES_DEFAULT   = 600;
    localparam int RAY_GEN_LATENCY = 4;

    typedef logic [9:0] pixel_coord_t;

    typedef struct packed {
        logic         valid;
        pixel_coord_t x;
        pixel_coord_t y;
        logic         first;
        logic         last;
        logic         eof;
    } ray_tag_t;

endpackage

// File: rtl/pixel_scanner_if.sv
// Scanner output bundle: sample request to the ray generator and the
// latency-matched tag presented alongside the generated ray.
interface pixel_scanner_if;
    import pixel_scanner_pkg::*;

    pixel_coord_t pixel_x;
    pixel_coord_t pixel_y;
    logic         pix_valid;
    logic         tag_valid;
    pixel_coord_t tag_x;
    pixel_coord_t tag_y;
    logic         tag_first;
    logic         tag_last;
    logic         frame_done;

    modport master (
        output pixel_x, pixel_y, pix_valid,
        output tag_valid, tag_x, tag_y, tag_first, tag_last, frame_done
    );

    modport slave (
        input pixel_x, pixel_y, pix_valid,
        input tag_valid, tag_x, tag_y, tag_first, tag_last, frame_done
    );
endinterface

// File: rtl/stall_delay_line.sv
// Enable-gated shift register of DEPTH stages for an arbitrary payload type.
// Holds all stages while en is low; async active-low reset clears every stage.
module stall_delay_line #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  T     din,
    output T     dout
);

    T stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pixel_scanner.sv
// Raster-order frame sequencer feeding the ray generator, with a stall-aware
// tag delay line. Define PIXEL_SCANNER_LOOP_EN for continuous back-to-back frames.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; counters at zero
//   ST_SCAN  | issuing one sample per enabled cycle in raster order
//   ST_DRAIN | flushing RAY_LATENCY cycles so the final tag reaches output
module pixel_scanner
    import pixel_scanner_pkg::*;
#(
    parameter int H_RES             = H_RES_DEFAULT,
    parameter int V_RES             = V_RES_DEFAULT,
    parameter int SAMPLES_PER_PIXEL = 4,
    parameter int RAY_LATENCY       = RAY_GEN_LATENCY
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            start,
    output logic            busy,
    pixel_scanner_if.master scan
);

    localparam int SW = (SAMPLES_PER_PIXEL > 1) ? $clog2(SAMPLES_PER_PIXEL) : 1;
    localparam int DW = (RAY_LATENCY > 1) ? $clog2(RAY_LATENCY) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(SAMPLES_PER_PIXEL - 1);
    localparam pixel_coord_t  X_LAST = pixel_coord_t'(H_RES - 1);
    localparam pixel_coord_t  Y_LAST = pixel_coord_t'(V_RES - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(RAY_LATENCY - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] s_cnt;
    pixel_coord_t  x_cnt;
    pixel_coord_t  y_cnt;
    logic [DW-1:0] drain_cnt;

    logic     en;
    logic     s_wrap;
    logic     x_wrap;
    logic     frame_end;
    ray_tag_t tag_in;
    ray_tag_t tag_out;

    assign en        = ~stall;
    assign s_wrap    = (s_cnt == S_LAST);
    assign x_wrap    = s_wrap && (x_cnt == X_LAST);
    assign frame_end = x_wrap && (y_cnt == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_cnt     <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            drain_cnt <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SCAN;
                        s_cnt <= '0;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (frame_end) begin
                        s_cnt <= '0;
                        x_cnt <= '0;
                        y_cnt <= '0;
`ifdef PIXEL_SCANNER_LOOP_EN
                        state <= ST_SCAN;
`else
                        state     <= ST_DRAIN;
                        drain_cnt <= D_LOAD;
`endif
                    end else if (x_wrap) begin
                        s_cnt <= '0;
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 10'd1;
                    end else if (s_wrap) begin
                        s_cnt <= '0;
                        x_cnt <= x_cnt + 10'd1;
                    end else begin
                        s_cnt <= s_cnt + SW'(1);
                    end
                end
                ST_DRAIN: begin
                    // Terminal count marks the cycle the final tag is presented.
                    if (drain_cnt == '0) state <= ST_IDLE;
                    else                 drain_cnt <= drain_cnt - DW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tag_in = '0;
        if (state == ST_SCAN) begin
            tag_in.valid = 1'b1;
            tag_in.x     = x_cnt;
            tag_in.y     = y_cnt;
            tag_in.first = (s_cnt == '0);
            tag_in.last  = s_wrap;
            tag_in.eof   = frame_end;
        end
    end

    stall_delay_line #(
        .DEPTH (RAY_LATENCY),
        .T     (ray_tag_t)
    ) u_tag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (tag_in),
        .dout  (tag_out)
    );

    assign busy            = (state != ST_IDLE);
    assign scan.pixel_x    = x_cnt;
    assign scan.pixel_y    = y_cnt;
    assign scan.pix_valid  = (state == ST_SCAN);
    assign scan.tag_valid  = tag_out.valid;
    assign scan.tag_x      = tag_out.x;
    assign scan.tag_y      = tag_out.y;
    assign scan.tag_first  = tag_out.first;
    assign scan.tag_last   = tag_out.last;
    assign scan.frame_done = tag_out.valid & tag_out.eof;

endmodule

// File: tb/tb_pixel_scanner.sv
// Bench for pixel_scanner: two configurations driven together, checked every
// cycle against a sample-index model, plus directed literal expectations.
module tb_pixel_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic start = 1'b0;
    logic busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_scanner_if a_if();
    pixel_scanner_if b_if();

    pixel_scanner #(.H_RES(4), .V_RES(3), .SAMPLES_PER_PIXEL(2), .RAY_LATENCY(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .start(start), .busy(busy_a), .scan(a_if));

    pixel_scanner #(.H_RES(2), .V_RES(2), .SAMPLES_PER_PIXEL(1), .RAY_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .start(start), .busy(busy_b), .scan(b_if));

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic [9:0] x;
        logic [9:0] y;
        logic       f;
        logic       l;
        logic       e;
    } mtag_t;

    int    P_H [2] = '{4, 2};
    int    P_V [2] = '{3, 2};
    int    P_S [2] = '{2, 1};
    int    P_L [2] = '{4, 2};
    int    mode [2];       // 0 idle, 1 scanning, 2 draining
    int    k [2];          // index of the sample currently issued
    int    dcnt [2];
    mtag_t hist [2][8];

    function automatic mtag_t tag_of(int i, int kk);
        mtag_t t;
        int pix = kk / P_S[i];
        int s   = kk % P_S[i];
        t.v = 1'b1;
        t.x = 10'(pix % P_H[i]);
        t.y = 10'(pix / P_H[i]);
        t.f = (s == 0);
        t.l = (s == P_S[i] - 1);
        t.e = (kk == P_H[i] * P_V[i] * P_S[i] - 1);
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; k[i] = 0; dcnt[i] = 0;
            for (int j = 0; j < 8; j++) hist[i][j] = '0;
        end
    endtask

    task automatic model_step(int i);
        int n = P_H[i] * P_V[i] * P_S[i];
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = (mode[i] == 1) ? tag_of(i, k[i]) : mtag_t'('0);
        case (mode[i])
            0: if (start) begin mode[i] = 1; k[i] = 0; end
            1: begin
                if (k[i] == n - 1) begin
                    k[i] = 0;
`ifndef PIXEL_SCANNER_LOOP_EN
                    mode[i] = 2; dcnt[i] = 0;
`endif
                end else k[i]++;
            end
            default: begin
                dcnt[i]++;
                if (dcnt[i] == P_L[i]) mode[i] = 0;
            end
        endcase
    endtask

    function automatic logic [45:0] exp_vec(int i);
        mtag_t cur = (mode[i] == 1) ? tag_of(i, k[i]) : mtag_t'('0);
        mtag_t t   = hist[i][P_L[i]-1];
        return {mode[i] != 0, mode[i] == 1, cur.x, cur.y,
                t.v, t.x, t.y, t.f, t.l, t.v & t.e};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [45:0] act_a, act_b;
    assign act_a = {busy_a, a_if.pix_valid, a_if.pixel_x, a_if.pixel_y, a_if.tag_valid,
                    a_if.tag_x, a_if.tag_y, a_if.tag_first, a_if.tag_last, a_if.frame_done};
    assign act_b = {busy_b, b_if.pix_valid, b_if.pixel_x, b_if.pixel_y, b_if.tag_valid,
                    b_if.tag_x, b_if.tag_y, b_if.tag_first, b_if.tag_last, b_if.frame_done};

    always @(negedge clk) begin
        check("a_outputs", 64'(act_a), 64'(exp_vec(0)));
        check("b_outputs", 64'(act_b), 64'(exp_vec(1)));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic st, input logic sta);
        stall = st;
        start = sta;
        @(posedge clk);
        if (rst_n && !st) for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [19:0] seq_a [64];
    logic [19:0] seq_b [16];
    int nv, nvb, fd_cnt, fd_at0, fd_at1, busy_low, bfl;
    logic [20:0] fd_tag;
    logic        busy29;
    logic [9:0]  cap_px, cap_tx;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0);

        // Frame with no stall, single start pulse.
        nv = 0; nvb = 0; fd_cnt = 0; fd_at0 = 0; fd_at1 = 0; busy_low = 0; bfl = 0;
        fd_tag = '0; busy29 = 1'b1;
        tick(0, 1);
        for (int c = 1; c <= 60; c++) begin
            if (a_if.pix_valid && nv < 64) begin seq_a[nv] = {a_if.pixel_x, a_if.pixel_y}; nv++; end
            if (b_if.pix_valid && nvb < 16) begin seq_b[nvb] = {b_if.pixel_x, b_if.pixel_y}; nvb++; end
            if (b_if.tag_valid && b_if.tag_first && b_if.tag_last) bfl++;
            if (a_if.frame_done) begin
                if (fd_cnt == 0) begin
                    fd_at0 = c;
                    fd_tag = {a_if.tag_x, a_if.tag_y, a_if.tag_last};
                end else if (fd_cnt == 1) fd_at1 = c;
                fd_cnt++;
            end
            if (!busy_a) busy_low++;
            if (c == 29) busy29 = busy_a;
            tick(0, 0);
        end
        check("seq0", 64'(seq_a[0]), {10'd0, 10'd0});
        check("seq1", 64'(seq_a[1]), {10'd0, 10'd0});
        check("seq2", 64'(seq_a[2]), {10'd1, 10'd0});
        check("seq7", 64'(seq_a[7]), {10'd3, 10'd0});
        check("seq8", 64'(seq_a[8]), {10'd0, 10'd1});
        check("seq23", 64'(seq_a[23]), {10'd3, 10'd2});
        check("fd_first_cycle", 64'(fd_at0), 64'd28);
        check("fd_tag", 64'(fd_tag), {10'd3, 10'd2, 1'b1});
        check("b_seq2", 64'(seq_b[2]), {10'd0, 10'd1});
`ifdef PIXEL_SCANNER_LOOP_EN
        check("loop_seq24", 64'(seq_a[24]), {10'd0, 10'd0});
        check("loop_fd_count", 64'(fd_cnt), 64'd2);
        check("loop_fd_second", 64'(fd_at1), 64'd52);
        check("loop_busy_low", 64'(busy_low), 64'd0);
`else
        check("pix_valid_count", 64'(nv), 64'd24);
        check("fd_count", 64'(fd_cnt), 64'd1);
        check("busy_after_done", 64'(busy29), 64'd0);
        check("b_pix_count", 64'(nvb), 64'd4);
        check("b_first_last_tags", 64'(bfl), 64'd4);
`endif

        // Stall at sample 5 and at the frame_done cycle.
        pulse_reset();
        tick(0, 1);
        repeat (5) tick(0, 0);
        check("stall_px_sample5", 64'(a_if.pixel_x), 64'd2);
        cap_px = a_if.pixel_x;
        cap_tx = a_if.tag_x;
        for (int c = 0; c < 3; c++) begin
            tick(1, 0);
            check("stall_px_frozen", 64'(a_if.pixel_x), 64'(cap_px));
            check("stall_tx_frozen", 64'(a_if.tag_x), 64'(cap_tx));
        end
        for (int c = 0; c < 100 && !a_if.frame_done; c++) tick(0, 0);
        check("stall_fd_seen", 64'(a_if.frame_done), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick(1, 0);
            check("fd_held", 64'(a_if.frame_done), 64'd1);
            check("fd_held_tag", 64'({a_if.tag_x, a_if.tag_y}), {10'd3, 10'd2});
        end
        tick(0, 0);
        check("fd_after_stall", 64'(a_if.frame_done), 64'd0);
`ifndef PIXEL_SCANNER_LOOP_EN
        check("busy_after_stall", 64'(busy_a), 64'd0);
`endif

        // start during SCAN and during stall in IDLE.
        pulse_reset();
        tick(0, 1);
        repeat (3) tick(0, 0);
        tick(0, 1);
        check("start_in_scan_px", 64'(a_if.pixel_x), 64'd2);
        repeat (40) tick(0, 0);
        tick(1, 1);
        tick(0, 0);
`ifndef PIXEL_SCANNER_LOOP_EN
        check("start_in_stall_busy", 64'(busy_a), 64'd0);
        check("start_in_stall_pv", 64'(a_if.pix_valid), 64'd0);
`endif

        // Asynchronous reset mid-frame.
        pulse_reset();
        tick(0, 1);
        repeat (10) tick(0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_outputs_zero", 64'(act_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            tick(0, 0);
            if (a_if.pix_valid) nv++;
        end
        check("no_restart_after_rst", 64'(nv), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) pulse_reset();
            else tick(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
